// File: rtl/prog_ram_loader.sv
// -----------------------------------------------------------------------------
// prog_ram_loader
//
// Program memory for the 16-bit processor with a streaming load port, a fetch
// port and a run controller. A host streams a program in one word per beat.
// The host then pulses go_i. The block raises start_o and serves fetches on
// pc_i. When pc_i hits HALT_ADDR it drains for DRAIN_CYCLES and then reports
// done_o.
//
// Ports:
//   clk_i, reset_i        single clock, synchronous active-high reset
//   load_valid_i/ready_o  load handshake
//   load_data_i           program word for the current beat
//   load_last_i           marks the final word of the program
//   go_i                  single-cycle run request (ARMED or DONE only)
//   pc_i, ram_read_en_i   fetch address and fetch enable from the processor
//   instr_o               fetched word, 1-cycle latency, holds when not fetching
//   start_o, done_o       processor run enable / run complete
//   load_count_o          number of words loaded so far
//   overflow_err_o        depth filled without load_last_i
//   checksum_o            running sum of loaded words
//
// Optional feature macro: PROG_RAM_CHECKSUM_EN
//   defined   -> checksum_o is the modulo-2**DATA_WIDTH sum of accepted words
//   undefined -> checksum_o is tied to zero and no adder is built
// -----------------------------------------------------------------------------
module prog_ram_loader #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 7,
    parameter int HALT_ADDR    = (2 ** ADDR_WIDTH) - 1,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  load_valid_i,
    output logic                  load_ready_o,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    input  logic                  load_last_i,
    input  logic                  go_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic                  ram_read_en_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic                  start_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH:0]   load_count_o,
    output logic                  overflow_err_o,
    output logic [DATA_WIDTH-1:0] checksum_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

    localparam logic [ADDR_WIDTH:0]   LAST_IDX   = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] HALT_PC    = ADDR_WIDTH'(HALT_ADDR);
    localparam logic [CNT_W-1:0]      DRAIN_INIT = CNT_W'(DRAIN_CYCLES);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_ARMED = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                state_q;
    logic                  load_ready_q;
    logic                  start_q;
    logic                  done_q;
    logic                  overflow_q;
    logic [ADDR_WIDTH:0]   load_count_q;
    logic [CNT_W-1:0]      drain_q;
    logic [DATA_WIDTH-1:0] instr_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  beat_accept_s;

    // load_ready_q is high exactly while in LOAD, so it doubles as the
    // acceptance qualifier.
    assign beat_accept_s = load_valid_i & load_ready_q;

    // Run controller: load sequencing, run/drain/done and the registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_LOAD;
            load_ready_q <= 1'b1;
            start_q      <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            load_count_q <= '0;
            drain_q      <= '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (beat_accept_s) begin
                        load_count_q <= load_count_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
                        // The beat that fills the last location ends the load
                        // even without load_last_i; that case is the overflow.
                        if (load_last_i || (load_count_q == LAST_IDX)) begin
                            state_q      <= S_ARMED;
                            load_ready_q <= 1'b0;
                            overflow_q   <= ~load_last_i;
                        end
                    end
                end
                S_ARMED: begin
                    if (go_i) begin
                        state_q <= S_RUN;
                        start_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (pc_i == HALT_PC) begin
                        state_q <= S_DRAIN;
                        drain_q <= DRAIN_INIT;
                    end
                end
                S_DRAIN: begin
                    // The count reaching 0 is folded into the ==1 test, so that
                    // start_o drops exactly DRAIN_CYCLES edges after the halt edge.
                    if (drain_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        state_q <= S_DONE;
                        drain_q <= '0;
                        start_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                S_DONE: begin
                    if (go_i) begin
                        state_q <= S_RUN;
                        start_q <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= S_LOAD;
                    load_ready_q <= 1'b1;
                    start_q      <= 1'b0;
                    done_q       <= 1'b0;
                    overflow_q   <= 1'b0;
                    load_count_q <= '0;
                    drain_q      <= '0;
                end
            endcase
        end
    end

    // Program storage write port. Contents survive reset; load_count masks reads.
    always_ff @(posedge clk_i) begin
        if (!reset_i && beat_accept_s) begin
            mem_q[load_count_q[ADDR_WIDTH-1:0]] <= load_data_i;
        end
    end

    // Fetch port: 1-cycle read, unloaded locations read as zero, holds when idle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            instr_q <= '0;
        end else if (ram_read_en_i) begin
            instr_q <= ({1'b0, pc_i} < load_count_q) ? mem_q[pc_i] : '0;
        end else begin
            instr_q <= instr_q;
        end
    end

`ifdef PROG_RAM_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_q;

    // Running load checksum; only accepted beats change it, so it freezes outside LOAD.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            checksum_q <= '0;
        end else if (beat_accept_s) begin
            checksum_q <= checksum_q + load_data_i;
        end else begin
            checksum_q <= checksum_q;
        end
    end

    assign checksum_o = checksum_q;
`else
    assign checksum_o = '0;
`endif

    assign load_ready_o   = load_ready_q;
    assign instr_o        = instr_q;
    assign start_o        = start_q;
    assign done_o         = done_q;
    assign load_count_o   = load_count_q;
    assign overflow_err_o = overflow_q;

endmodule
